// File: rtl/decode_stage.sv
// decode_stage: instruction-decode stage of a 5-stage 32-bit MIPS pipeline.
// Contains the IF/ID register, 32x32 register file with write-through bypass,
// the main control decoder, load-use hazard detection, and the ID/EX register.
// Ports:
//   clk, reset                   clock, async active-high reset
//   inst, ifOut                  instruction and PC+4 from fetch
//   Jump, BranchTaken            flush requests
//   RegWrite_wb/WriteReg_wb/WriteData_wb   write-back port
//   PCWrite                      0 freezes fetch (combinational)
//   instruct..idex_valid         registered ID/EX outputs to execute
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic [31:0] ifOut,
  input  logic        Jump,
  input  logic        BranchTaken,
  input  logic        RegWrite_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] WriteData_wb,
  output logic        PCWrite,
  output logic [31:0] instruct,
  output logic [31:0] address,
  output logic [31:0] mem1Read,
  output logic [31:0] mem2Read,
  output logic [31:0] signExnd,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        idex_valid
);

  logic [31:0] r_ifid_inst;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic [31:0] r_regs [32];

  logic [4:0]  w_rs_idx, w_rt_idx;
  logic [31:0] w_rs_data, w_rt_data;
  logic        w_wb_en;
  logic        w_flush, w_stall;
  logic        w_regdst, w_alusrc, w_memtoreg, w_regwrite;
  logic        w_memread, w_memwrite, w_branch;
  logic [1:0]  w_aluop;

  assign w_rs_idx = r_ifid_inst[25:21];
  assign w_rt_idx = r_ifid_inst[20:16];
  assign w_wb_en  = RegWrite_wb && (WriteReg_wb != 5'd0);
  assign w_flush  = Jump | BranchTaken;

  // Reads bypass a same-cycle write-back so decode never sees a stale value.
  always_comb begin
    w_rs_data = r_regs[w_rs_idx];
    w_rt_data = r_regs[w_rt_idx];
    if (w_wb_en && WriteReg_wb == w_rs_idx) w_rs_data = WriteData_wb;
    if (w_wb_en && WriteReg_wb == w_rt_idx) w_rt_data = WriteData_wb;
    if (w_rs_idx == 5'd0) w_rs_data = '0;
    if (w_rt_idx == 5'd0) w_rt_data = '0;
  end

  always_comb begin
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_aluop    = 2'b00;
    if (r_ifid_valid) begin
      case (r_ifid_inst[31:26])
        6'h00: begin w_regdst = 1'b1; w_regwrite = 1'b1; w_aluop = 2'b10; end
        6'h23: begin
          w_alusrc = 1'b1; w_memtoreg = 1'b1; w_regwrite = 1'b1; w_memread = 1'b1;
        end
        6'h2B: begin w_alusrc = 1'b1; w_memwrite = 1'b1; end
        6'h04: begin w_branch = 1'b1; w_aluop = 2'b01; end
        6'h08: begin w_alusrc = 1'b1; w_regwrite = 1'b1; end
        default: ;
      endcase
    end
  end

  // Load-use: the load in ID/EX targets a register the instruction in IF/ID reads.
  assign w_stall = idex_valid && MemRead && (rt != 5'd0) &&
                   ((rt == w_rs_idx) || (rt == w_rt_idx)) && r_ifid_valid;
  assign PCWrite = ~w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[WriteReg_wb] <= WriteData_wb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifid_inst  <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_flush) begin
      r_ifid_inst  <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (!w_stall) begin
      r_ifid_inst  <= inst;
      r_ifid_pc4   <= ifOut;
      r_ifid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || w_flush || w_stall) begin
      // Flush and stall share the same bubble; reset clears identically.
      instruct   <= '0;
      address    <= '0;
      mem1Read   <= '0;
      mem2Read   <= '0;
      signExnd   <= '0;
      rs         <= '0;
      rt         <= '0;
      rd         <= '0;
      RegDst     <= 1'b0;
      ALUSrc     <= 1'b0;
      MemtoReg   <= 1'b0;
      RegWrite   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Branch     <= 1'b0;
      ALUOp      <= 2'b00;
      idex_valid <= 1'b0;
    end else begin
      instruct   <= r_ifid_inst;
      address    <= r_ifid_pc4;
      mem1Read   <= w_rs_data;
      mem2Read   <= w_rt_data;
      signExnd   <= {{16{r_ifid_inst[15]}}, r_ifid_inst[15:0]};
      rs         <= w_rs_idx;
      rt         <= w_rt_idx;
      rd         <= r_ifid_inst[15:11];
      RegDst     <= w_regdst;
      ALUSrc     <= w_alusrc;
      MemtoReg   <= w_memtoreg;
      RegWrite   <= w_regwrite;
      MemRead    <= w_memread;
      MemWrite   <= w_memwrite;
      Branch     <= w_branch;
      ALUOp      <= w_aluop;
      idex_valid <= r_ifid_valid;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst, ifOut;
  logic        Jump, BranchTaken, RegWrite_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] WriteData_wb;
  logic        PCWrite;
  logic [31:0] instruct, address, mem1Read, mem2Read, signExnd;
  logic [4:0]  rs, rt, rd;
  logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;
  logic        idex_valid;

  decode_stage dut (
    .clk(clk), .reset(reset), .inst(inst), .ifOut(ifOut), .Jump(Jump),
    .BranchTaken(BranchTaken), .RegWrite_wb(RegWrite_wb), .WriteReg_wb(WriteReg_wb),
    .WriteData_wb(WriteData_wb), .PCWrite(PCWrite), .instruct(instruct),
    .address(address), .mem1Read(mem1Read), .mem2Read(mem2Read), .signExnd(signExnd),
    .rs(rs), .rt(rt), .rd(rd), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .ALUOp(ALUOp), .idex_valid(idex_valid)
  );

  always #5 clk = ~clk;

  // ctrl = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
  typedef struct packed {
    logic [31:0] instruct, address, m1, m2, sx;
    logic [4:0]  rs, rt, rd;
    logic [8:0]  ctrl;
    logic        valid;
  } idex_t;

  int n_pass = 0;
  int n_total = 0;
  bit done = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  idex_t       m_idex;
  logic [31:0] m_ifid_inst, m_ifid_pc4;
  logic        m_ifid_valid;
  logic [31:0] m_rf [32];

  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b100100010;
      6'h23:   return 9'b011110000;
      6'h2B:   return 9'b010001000;
      6'h04:   return 9'b000000101;
      6'h08:   return 9'b010100000;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (RegWrite_wb && WriteReg_wb == idx) return WriteData_wb;
    return m_rf[idx];
  endfunction

  function automatic logic model_stall();
    logic [4:0] a, b;
    a = m_ifid_inst[25:21];
    b = m_ifid_inst[20:16];
    return m_idex.valid && m_idex.ctrl[4] && (m_idex.rt != 0) &&
           ((m_idex.rt == a) || (m_idex.rt == b)) && m_ifid_valid;
  endfunction

  always @(posedge clk or posedge reset) begin
    idex_t nx;
    logic  st, fl;
    if (reset) begin
      m_idex = '0;
      m_ifid_inst = 0; m_ifid_pc4 = 0; m_ifid_valid = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      st = model_stall();
      fl = Jump | BranchTaken;
      nx = '0;
      if (!(fl || st)) begin
        nx.instruct = m_ifid_inst;
        nx.address  = m_ifid_pc4;
        nx.m1       = read_reg(m_ifid_inst[25:21]);
        nx.m2       = read_reg(m_ifid_inst[20:16]);
        nx.sx       = 32'($signed(m_ifid_inst[15:0]));
        nx.rs       = m_ifid_inst[25:21];
        nx.rt       = m_ifid_inst[20:16];
        nx.rd       = m_ifid_inst[15:11];
        nx.ctrl     = m_ifid_valid ? ctrl_of(m_ifid_inst[31:26]) : 9'd0;
        nx.valid    = m_ifid_valid;
      end
      if (RegWrite_wb && WriteReg_wb != 0) m_rf[WriteReg_wb] = WriteData_wb;
      if (fl) begin
        m_ifid_inst = 0; m_ifid_pc4 = 0; m_ifid_valid = 0;
      end else if (!st) begin
        m_ifid_inst = inst; m_ifid_pc4 = ifOut; m_ifid_valid = 1;
      end
      m_idex = nx;
    end
  end

  idex_t dut_vec;
  assign dut_vec = {instruct, address, mem1Read, mem2Read, signExnd, rs, rt, rd,
                    RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
                    ALUOp, idex_valid};

  // Continuous compare against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        check("idex_model", 192'(dut_vec), 192'(m_idex));
        check("pcwrite_model", 192'(PCWrite), 192'(!model_stall()));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    ifOut = ifOut + 32'd4;
  endtask

  logic [8:0] exp_ctrl [7];
  logic [5:0] ops [7];

  initial begin
    reset = 1; inst = 32'h0; ifOut = 32'h0; Jump = 0; BranchTaken = 0;
    RegWrite_wb = 0; WriteReg_wb = 0; WriteData_wb = 0;
    tick(); tick();
    reset = 0;

    // addi $1,$0,5
    inst = 32'h20010005; tick();
    inst = 32'h0; tick();
    check("addi_alusrc", 192'(ALUSrc), 192'(1'b1));
    check("addi_regwrite", 192'(RegWrite), 192'(1'b1));
    check("addi_signext", 192'(signExnd), 192'(32'd5));
    check("addi_rt", 192'(rt), 192'(5'd1));
    check("addi_valid", 192'(idex_valid), 192'(1'b1));

    // bypass: add $3,$8,$0 in IF/ID while r8 <= DEADBEEF
    inst = 32'h01001820; tick();
    RegWrite_wb = 1; WriteReg_wb = 5'd8; WriteData_wb = 32'hDEADBEEF; inst = 32'h01084820;
    tick();
    check("bypass_rs_data", 192'(mem1Read), 192'(32'hDEADBEEF));
    check("bypass_rd", 192'(rd), 192'(5'd3));
    RegWrite_wb = 0; inst = 32'h0; tick();
    check("stored_r8", 192'(mem2Read), 192'(32'hDEADBEEF));

    // write to r0 is discarded
    inst = 32'h00002820; tick();
    RegWrite_wb = 1; WriteReg_wb = 5'd0; WriteData_wb = 32'h1234; inst = 32'h0; tick();
    check("r0_reads_zero", 192'(mem1Read), 192'(32'd0));
    RegWrite_wb = 0;

    // negative immediate
    inst = 32'h2002FFFC; tick();
    inst = 32'h0; tick();
    check("signext_neg", 192'(signExnd), 192'(32'hFFFFFFFC));

    // load-use: lw $2,0($1); add $4,$2,$3
    inst = 32'h8C220000; tick();
    check("lu_pc_before", 192'(PCWrite), 192'(1'b1));
    inst = 32'h00432020; tick();
    check("lu_pc_stall", 192'(PCWrite), 192'(1'b0));
    check("lu_lw_memread", 192'(MemRead), 192'(1'b1));
    inst = 32'h00003020; tick();
    check("lu_bubble_valid", 192'(idex_valid), 192'(1'b0));
    check("lu_bubble_ctrl", 192'({RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}), 192'(9'd0));
    check("lu_pc_after", 192'(PCWrite), 192'(1'b1));
    inst = 32'h0; tick();
    check("lu_add_rs", 192'(rs), 192'(5'd2));
    check("lu_add_inst", 192'(instruct), 192'(32'h00432020));

    // lw to r0: no stall
    inst = 32'h8C200000; tick();
    inst = 32'h00032020; tick();
    check("lw_r0_nostall", 192'(PCWrite), 192'(1'b1));
    inst = 32'h0; tick();
    check("lw_r0_add", 192'(instruct), 192'(32'h00032020));

    // BranchTaken flush with sub in IF/ID
    inst = 32'h00223822; tick();
    BranchTaken = 1; inst = 32'h2003000A; tick();
    check("br_bubble", 192'(idex_valid), 192'(1'b0));
    check("br_bubble_inst", 192'(instruct), 192'(32'd0));
    BranchTaken = 0; inst = 32'h2004000B; tick();
    check("br_ifid_cleared", 192'(idex_valid), 192'(1'b0));
    inst = 32'h0; tick();
    check("br_next_inst", 192'(instruct), 192'(32'h2004000B));

    // Jump flush
    inst = 32'h00223822; tick();
    Jump = 1; inst = 32'h2003000A; tick();
    check("j_bubble", 192'(idex_valid), 192'(1'b0));
    Jump = 0; inst = 32'h2005000C; tick();
    check("j_ifid_cleared", 192'(idex_valid), 192'(1'b0));
    inst = 32'h0; tick();
    check("j_next_inst", 192'(instruct), 192'(32'h2005000C));

    // flush coincident with load-use stall
    inst = 32'h8C220000; tick();
    inst = 32'h00432020; tick();
    Jump = 1; inst = 32'h20050001; #1;
    check("fs_pc_stall", 192'(PCWrite), 192'(1'b0));
    tick();
    check("fs_bubble", 192'(idex_valid), 192'(1'b0));
    Jump = 0; inst = 32'h20060002; tick();
    check("fs_ifid_cleared", 192'(idex_valid), 192'(1'b0));
    check("fs_pc_free", 192'(PCWrite), 192'(1'b1));
    inst = 32'h0; tick();
    check("fs_next_inst", 192'(instruct), 192'(32'h20060002));
    tick();
    check("fs_no_dup", 192'(instruct), 192'(32'h0));

    // decoder sweep
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};
    exp_ctrl = '{9'b100100010, 9'b011110000, 9'b010001000, 9'b000000101,
                 9'b010100000, 9'b000000000, 9'b000000000};
    for (int k = 0; k < 7; k++) begin
      inst = {ops[k], 26'h0220000}; tick();
      inst = 32'h0; tick();
      check($sformatf("decode_op%02h", ops[k]),
            192'({RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}),
            192'(exp_ctrl[k]));
    end

    // asynchronous reset mid-stream
    inst = 32'h20010005; tick();
    inst = 32'h8C220000; tick();
    #2 reset = 1;
    #1;
    check("rst_instruct", 192'(instruct), 192'(32'd0));
    check("rst_signext", 192'(signExnd), 192'(32'd0));
    check("rst_valid", 192'(idex_valid), 192'(1'b0));
    check("rst_pcwrite", 192'(PCWrite), 192'(1'b1));
    @(posedge clk); #1;
    reset = 0; inst = 32'h20010005; tick();
    inst = 32'h01001820; tick();
    check("post_rst_addi_sx", 192'(signExnd), 192'(32'd5));
    check("post_rst_addi_ctrl", 192'({ALUSrc, RegWrite, idex_valid}), 192'(3'b111));
    inst = 32'h0; tick();
    check("post_rst_r8_cleared", 192'(mem1Read), 192'(32'd0));
    tick();

    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
